// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the fetch sequencer slice.
//   - fetch_state_e      : sequencer FSM states
//   - FETCH_PC_W_DEFAULT : default program-counter width
//   - branch_offset()    : branch-offset table lookup (indices 0..7 -> 1,2,3,4,6,8,12,16)
package fetch_pkg;

  localparam int FETCH_PC_W_DEFAULT = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_ISSUE   = 3'd2,
    ST_RESOLVE = 3'd3,
    ST_HALTED  = 3'd4
  } fetch_state_e;

  localparam logic [4:0] OFFSET_0 = 5'd1;
  localparam logic [4:0] OFFSET_1 = 5'd2;
  localparam logic [4:0] OFFSET_2 = 5'd3;
  localparam logic [4:0] OFFSET_3 = 5'd4;
  localparam logic [4:0] OFFSET_4 = 5'd6;
  localparam logic [4:0] OFFSET_5 = 5'd8;
  localparam logic [4:0] OFFSET_6 = 5'd12;
  localparam logic [4:0] OFFSET_7 = 5'd16;

  function automatic logic [4:0] branch_offset(input logic [2:0] sel);
    logic [4:0] off;
    case (sel)
      3'd0:    off = OFFSET_0;
      3'd1:    off = OFFSET_1;
      3'd2:    off = OFFSET_2;
      3'd3:    off = OFFSET_3;
      3'd4:    off = OFFSET_4;
      3'd5:    off = OFFSET_5;
      3'd6:    off = OFFSET_6;
      3'd7:    off = OFFSET_7;
      default: off = OFFSET_0;
    endcase
    return off;
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: instruction-memory req/valid handshake.
//   imem_req_o   : fetch request (sequencer -> memory), held until valid
//   imem_addr_o  : fetch address, stable while requesting
//   imem_valid_i : memory returns data this cycle (memory -> sequencer)
//   imem_data_i  : instruction byte
// Modports: master = sequencer side, slave = memory side.
interface fetch_sequencer_if
  import fetch_pkg::*;
#(
  parameter int PC_W = FETCH_PC_W_DEFAULT
);
  logic            imem_req_o;
  logic [PC_W-1:0] imem_addr_o;
  logic            imem_valid_i;
  logic [7:0]      imem_data_i;

  modport master (output imem_req_o, output imem_addr_o, input imem_valid_i, input imem_data_i);
  modport slave  (input imem_req_o, input imem_addr_o, output imem_valid_i, output imem_data_i);
endinterface

// File: rtl/fetch_sequencer_branch_target.sv
// branch_target: combinational next-PC computation.
//   pc_i      : current PC
//   sel_i     : branch-offset table index
//   fwd_i     : forward branch taken (has priority over bwd_i)
//   bwd_i     : backward branch taken
//   next_pc_o : PC +/- offset, or PC + 1; arithmetic wraps modulo 2^PC_W
module branch_target
  import fetch_pkg::*;
#(
  parameter int PC_W = FETCH_PC_W_DEFAULT
) (
  input  logic [PC_W-1:0] pc_i,
  input  logic [2:0]      sel_i,
  input  logic            fwd_i,
  input  logic            bwd_i,
  output logic [PC_W-1:0] next_pc_o
);

  logic [PC_W-1:0] offset_s;

  // Offset is zero-extended to PC width so wrap falls out of the PC-width add.
  assign offset_s = PC_W'(branch_offset(sel_i));

  // Select forward / backward / sequential target.
  always_comb begin
    next_pc_o = pc_i;
    if (fwd_i) begin
      next_pc_o = pc_i + offset_s;
    end else if (bwd_i) begin
      next_pc_o = pc_i - offset_s;
    end else begin
      next_pc_o = pc_i + PC_W'(1'b1);
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: fetches instructions over a req/valid handshake, issues each
// for one cycle to the decoder, then resolves done/branch to form the next PC.
//   clock_i, reset_n_i         : clock, async active-low reset
//   start_i                    : begin at PC 0 from IDLE or HALTED
//   imem (master)              : instruction-memory handshake
//   instruction_o/instr_valid_o: instruction to decoder, valid in ISSUE
//   branchf_i/branchb_i/branch_sel_i/done_i : decoder results, used in RESOLVE
//   busy_o, halted_o, pc_o     : registered status
// Optional build macro FETCH_CYCLE_COUNT_EN adds cycle_count_o, a saturating
// count of busy cycles since the last accepted start.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int PC_W = FETCH_PC_W_DEFAULT
) (
  input  logic              clock_i,
  input  logic              reset_n_i,
  input  logic              start_i,
  fetch_sequencer_if.master imem,
  output logic [7:0]        instruction_o,
  output logic              instr_valid_o,
  input  logic              branchf_i,
  input  logic              branchb_i,
  input  logic [2:0]        branch_sel_i,
  input  logic              done_i,
  output logic              busy_o,
  output logic              halted_o,
  output logic [PC_W-1:0]   pc_o
`ifdef FETCH_CYCLE_COUNT_EN
  ,
  output logic [15:0]       cycle_count_o
`endif
);

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [7:0]      instr_q, instr_d;
  logic            req_q, req_d;
  logic            iv_q, iv_d;
  logic            busy_q, busy_d;
  logic            halted_q, halted_d;
  logic [PC_W-1:0] target_s;
  logic            start_acc_s;

  branch_target #(.PC_W(PC_W)) u_branch_target (
    .pc_i      (pc_q),
    .sel_i     (branch_sel_i),
    .fwd_i     (branchf_i),
    .bwd_i     (branchb_i),
    .next_pc_o (target_s)
  );

  assign start_acc_s = start_i && ((state_q == ST_IDLE) || (state_q == ST_HALTED));

  // Next-state, PC and instruction latch; status flags decode the next state so they are registered.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    case (state_q)
      ST_IDLE, ST_HALTED: begin
        if (start_i) begin
          state_d = ST_FETCH;
          pc_d    = '0;
        end else begin
          state_d = state_q;
        end
      end
      ST_FETCH: begin
        // req is always high in FETCH, so valid here is always a qualified return.
        if (imem.imem_valid_i) begin
          instr_d = imem.imem_data_i;
          state_d = ST_ISSUE;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_ISSUE: begin
        state_d = ST_RESOLVE;
      end
      ST_RESOLVE: begin
        if (done_i) begin
          state_d = ST_HALTED;
        end else begin
          pc_d    = target_s;
          state_d = ST_FETCH;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    req_d    = (state_d == ST_FETCH);
    iv_d     = (state_d == ST_ISSUE);
    busy_d   = (state_d == ST_FETCH) || (state_d == ST_ISSUE) || (state_d == ST_RESOLVE);
    halted_d = (state_d == ST_HALTED);
  end

  // State, PC, instruction and status registers.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= ST_IDLE;
      pc_q     <= '0;
      instr_q  <= 8'h00;
      req_q    <= 1'b0;
      iv_q     <= 1'b0;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      req_q    <= req_d;
      iv_q     <= iv_d;
      busy_q   <= busy_d;
      halted_q <= halted_d;
    end
  end

  assign imem.imem_req_o  = req_q;
  assign imem.imem_addr_o = pc_q;
  assign instruction_o    = instr_q;
  assign instr_valid_o    = iv_q;
  assign busy_o           = busy_q;
  assign halted_o         = halted_q;
  assign pc_o             = pc_q;

`ifdef FETCH_CYCLE_COUNT_EN
  logic [15:0] cnt_q, cnt_d;

  // Busy-cycle counter: clears on accepted start, saturates, holds otherwise.
  always_comb begin
    cnt_d = cnt_q;
    if (start_acc_s) begin
      cnt_d = 16'h0000;
    end else if (busy_q && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'h0001;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt_q <= 16'h0000;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cycle_count_o = cnt_q;
`else
  logic unused_s;
  assign unused_s = start_acc_s;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;
  import fetch_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] instruction;
  logic       instr_valid;
  logic       branchf = 1'b0, branchb = 1'b0, done = 1'b0;
  logic [2:0] branch_sel = 3'd0;
  logic       busy, halted;
  logic [7:0] pc;
`ifdef FETCH_CYCLE_COUNT_EN
  logic [15:0] cycle_count;
`endif

  fetch_sequencer_if #(.PC_W(8)) imem ();

  fetch_sequencer #(.PC_W(8)) dut (
    .clock_i       (clk),
    .reset_n_i     (rst_n),
    .start_i       (start),
    .imem          (imem),
    .instruction_o (instruction),
    .instr_valid_o (instr_valid),
    .branchf_i     (branchf),
    .branchb_i     (branchb),
    .branch_sel_i  (branch_sel),
    .done_i        (done),
    .busy_o        (busy),
    .halted_o      (halted),
    .pc_o          (pc)
`ifdef FETCH_CYCLE_COUNT_EN
    ,
    .cycle_count_o (cycle_count)
`endif
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // ---------------- reference model state ----------------
  int OFF [8] = '{1, 2, 3, 4, 6, 8, 12, 16};
  logic [7:0] mem [256];
  typedef struct {bit f; bit b; bit d; logic [2:0] sel; int exp;} step_t;
  step_t script_q[$];

  int  exp_addr_q[$];
  int  exp_instr_q[$];   // {pc, instruction}
  int  exp_wait_q[$];
  int  exp_halt_q[$];    // pc
  int  exp_cnt_q[$];

  bit  m_run = 0;
  int  m_pc = 0;
  int  m_cnt = 0;
  int  resolve_cd = 0;
  bit  pending = 0;
  int  wait_cnt = 0;
  int  wait_cur = 0;
  int  forced_wait = -1;
  bit  mon_en = 0;

  function automatic step_t mk(bit f, bit b, bit d, logic [2:0] sel, int exp);
    step_t s;
    s.f = f; s.b = b; s.d = d; s.sel = sel; s.exp = exp;
    return s;
  endfunction

  // One stimulus cycle, executed at a negative edge.
  task automatic step(input bit allow_start, input bit force_done);
    int nxt;
    step_t s;
    @(negedge clk);
    start = 1'b0;
    imem.imem_valid_i = 1'b0;
    imem.imem_data_i = 8'($urandom);
    branchf = 1'($urandom);
    branchb = 1'($urandom);
    branch_sel = 3'($urandom);
    done = ($urandom_range(0, 9) == 0);
    if (m_run) m_cnt++;
    // start: accepted only when the model is idle/halted
    if (!m_run) begin
      if (allow_start && ($urandom_range(0, 1) == 0)) begin
        start = 1'b1;
        m_run = 1;
        m_pc = 0;
        m_cnt = 0;
        exp_addr_q.push_back(0);
      end
    end else if ($urandom_range(0, 15) == 0) begin
      start = 1'b1;
    end
    // resolve: decoder outputs presented two cycles after the data beat
    if (resolve_cd > 0) begin
      resolve_cd--;
      if (resolve_cd == 0) begin
        s = mk(1'b0, 1'b0, 1'b0, 3'd0, -1);
        if (script_q.size() > 0) begin
          s = script_q.pop_front();
          branchf = s.f; branchb = s.b; done = s.d; branch_sel = s.sel;
        end else if (force_done) begin
          done = 1'b1;
        end
        if (done) begin
          m_run = 0;
          exp_halt_q.push_back(m_pc);
          exp_cnt_q.push_back(m_cnt);
        end else begin
          if (branchf) nxt = (m_pc + OFF[branch_sel]) % 256;
          else if (branchb) nxt = (m_pc - OFF[branch_sel] + 256) % 256;
          else nxt = (m_pc + 1) % 256;
          m_pc = nxt;
          exp_addr_q.push_back((s.exp >= 0) ? s.exp : nxt);
        end
      end
    end
    // memory responder
    if (imem.imem_req_o === 1'b1) begin
      if (!pending) begin
        pending = 1;
        wait_cur = (forced_wait >= 0) ? forced_wait : $urandom_range(0, 3);
        forced_wait = -1;
        wait_cnt = wait_cur;
      end
      if (wait_cnt == 0) begin
        imem.imem_valid_i = 1'b1;
        imem.imem_data_i = mem[imem.imem_addr_o];
        exp_instr_q.push_back((m_pc << 8) | int'(mem[m_pc]));
        exp_wait_q.push_back(wait_cur);
        pending = 0;
        resolve_cd = 2;
      end else begin
        wait_cnt--;
      end
    end else if ($urandom_range(0, 7) == 0) begin
      imem.imem_valid_i = 1'b1;   // unrequested return, must be ignored
    end
  endtask

  // ---------------- monitor ----------------
  int  cyc = 0;
  int  req_rise_cyc = 0;
  int  last_iv = -1;
  bit  prev_req = 0, prev_iv = 0, prev_halted = 0;
  int  halt_cnt = 0;

  initial begin
    int e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        cyc++;
        if (imem.imem_req_o && !prev_req) begin
          check("addr_expected", 32'(exp_addr_q.size() > 0), 32'd1);
          if (exp_addr_q.size() > 0) begin
            e = exp_addr_q.pop_front();
            check("fetch_addr", 32'(imem.imem_addr_o), 32'(e));
          end
          if (last_iv >= 0) check("issue_to_fetch_gap", 32'(cyc - last_iv), 32'd2);
`ifdef FETCH_CYCLE_COUNT_EN
          else check("count_cleared", 32'(cycle_count), 32'd0);
`endif
          req_rise_cyc = cyc;
        end
        if (instr_valid) begin
          check("iv_single_cycle", 32'(prev_iv), 32'd0);
          check("instr_expected", 32'(exp_instr_q.size() > 0), 32'd1);
          if (exp_instr_q.size() > 0) begin
            e = exp_instr_q.pop_front();
            check("instr_pc", {16'h0, pc, instruction}, 32'(e));
            e = exp_wait_q.pop_front();
            check("fetch_latency", 32'(cyc - req_rise_cyc), 32'(e + 1));
          end
          last_iv = cyc;
        end
        if (halted && !prev_halted) begin
          check("halt_expected", 32'(exp_halt_q.size() > 0), 32'd1);
          if (exp_halt_q.size() > 0) begin
            e = exp_halt_q.pop_front();
            check("halt_pc", 32'(pc), 32'(e));
            e = exp_cnt_q.pop_front();
`ifdef FETCH_CYCLE_COUNT_EN
            check("halt_count", 32'(cycle_count), 32'(e));
            halt_cnt = int'(cycle_count);
`endif
          end
          check("halt_not_busy", 32'(busy), 32'd0);
          if (last_iv >= 0) check("issue_to_halt_gap", 32'(cyc - last_iv), 32'd2);
          last_iv = -1;
        end
`ifdef FETCH_CYCLE_COUNT_EN
        if (halted && prev_halted) check("count_frozen", 32'(cycle_count), 32'(halt_cnt));
`endif
        prev_req = imem.imem_req_o;
        prev_iv = instr_valid;
        prev_halted = halted;
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int guard;
    imem.imem_valid_i = 1'b0;
    imem.imem_data_i = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h41;

    // reset values
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_req", 32'(imem.imem_req_o), 32'd0);
    check("rst_addr", 32'(imem.imem_addr_o), 32'd0);
    check("rst_instr", 32'(instruction), 32'h00);
    check("rst_flags", {29'd0, instr_valid, busy, halted}, 32'd0);

    // reset asserted mid-fetch drops the request immediately
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("fetch_req_up", {30'd0, imem.imem_req_o, busy}, 32'd3);
    #2 rst_n = 1'b0;
    #1 check("async_req_drop", 32'(imem.imem_req_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    imem.imem_valid_i = 1'b1;
    imem.imem_data_i = 8'hFF;
    @(negedge clk);
    imem.imem_valid_i = 1'b0;
    @(negedge clk);
    check("post_rst_idle", {22'd0, imem.imem_req_o, busy, instruction}, 32'd0);
    check("post_rst_pc", 32'(pc), 32'd0);

    // scripted first run: boundaries and priority
    forced_wait = 2;
    for (int i = 0; i < 3; i++) script_q.push_back(mk(1'b0, 1'b0, 1'b0, 3'd0, i + 1));
    script_q.push_back(mk(1'b0, 1'b1, 1'b0, 3'd7, 243));
    for (int i = 0; i < 12; i++) script_q.push_back(mk(1'b0, 1'b0, 1'b0, 3'd0, -1));
    script_q.push_back(mk(1'b0, 1'b0, 1'b0, 3'd0, 0));
    for (int i = 0; i < 9; i++) script_q.push_back(mk(1'b0, 1'b0, 1'b0, 3'd0, -1));
    script_q.push_back(mk(1'b0, 1'b0, 1'b0, 3'd0, 10));
    script_q.push_back(mk(1'b1, 1'b0, 1'b0, 3'd5, 18));
    script_q.push_back(mk(1'b1, 1'b0, 1'b1, 3'd0, -1));
    mon_en = 1;

    guard = 0;
    while (script_q.size() > 0 && guard < 2000) begin
      step(1'b1, 1'b0);
      guard++;
    end
    check("script_consumed", 32'(script_q.size()), 32'd0);

    // randomized phase
    for (int i = 0; i < 4000; i++) step(1'b1, 1'b0);

    // drain: stop restarting and force a halt at the next resolve
    guard = 0;
    while (m_run && guard < 100) begin
      step(1'b0, 1'b1);
      guard++;
    end
    check("drain_halted", 32'(m_run), 32'd0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1);
    check("queues_empty",
          32'(exp_addr_q.size() + exp_instr_q.size() + exp_halt_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction fetch and sequencing unit that drives the 8-bit instruction stream into the control decoder and acts on the decoder's branch/halt outputs. Holds the program counter (PC) and fetches from instruction memory over a req/valid handshake. Presents each instruction for one cycle, then resolves `branchf`/`branchb`/`done` and computes the next PC. Sits between instruction memory and the control decoder in the single-cycle-issue datapath.

## Interface
- `PC_W`, default 8: program counter and instruction-memory address width.
- `clock_i`  in  1  single clock, all state on rising edge.
- `reset_n_i`  in  1  asynchronous, active-low reset.
- `start_i`  in  1  pulse; leaves IDLE or HALTED and begins fetching at PC 0.
- `imem_req_o`  out  1  fetch request, held until `imem_valid_i`.
- `imem_addr_o`  out  PC_W  fetch address (current PC), stable while `imem_req_o`=1.
- `imem_valid_i`  in  1  memory has returned data this cycle.
- `imem_data_i`  in  8  instruction byte, sampled when `imem_valid_i`=1 and `imem_req_o`=1.
- `instruction_o`  out  8  instruction to the decoder.
- `instr_valid_o`  out  1  high for exactly the ISSUE cycle.
- `branchf_i`  in  1  forward branch taken, from the decoder.
- `branchb_i`  in  1  backward branch taken, from the decoder.
- `branch_sel_i`  in  3  branch-offset table index (decoder `rs_addr`).
- `done_i`  in  1  halt, from the decoder.
- `busy_o`  out  1  high in FETCH, ISSUE, RESOLVE.
- `halted_o`  out  1  high in HALTED.
- `pc_o`  out  PC_W  current PC.

## Operation
- States: IDLE, FETCH, ISSUE, RESOLVE, HALTED.
- IDLE: `start_i` -> PC=0, go to FETCH.
- FETCH: `imem_req_o`=1, `imem_addr_o`=PC. On `imem_valid_i` latch `imem_data_i` into `instruction_o` and go to ISSUE. The FSM waits indefinitely otherwise.
- ISSUE: `instr_valid_o`=1. The decoder registers its outputs at the closing edge. Go to RESOLVE.
- RESOLVE: sample decoder outputs. Priority is `done_i` > `branchf_i` > `branchb_i` > sequential.
  - done: go to HALTED, PC unchanged.
  - branchf: PC = PC + OFFSET[branch_sel_i].
  - branchb: PC = PC − OFFSET[branch_sel_i].
  - else: PC = PC + 1.
  - For every case except done, go to FETCH.
- PC arithmetic is modulo 2^PC_W: wraps silently both ways. OFFSET is zero-extended to PC_W.
- HALTED: `start_i` restarts at PC 0. All other inputs are ignored.
- `start_i` outside IDLE/HALTED is ignored.
- `imem_valid_i` without `imem_req_o` is ignored.
- Reset values: state IDLE, PC 0, `instruction_o` 8'h00, `imem_req_o` 0, `instr_valid_o` 0, `busy_o` 0, `halted_o` 0, `imem_addr_o` 0.
- Reset asserted mid-fetch drops `imem_req_o` immediately (asynchronous). Any later `imem_valid_i` is ignored.

## Timing
- Minimum 3 cycles per instruction: FETCH (valid same cycle), ISSUE, RESOLVE. Each extra memory wait cycle adds one.
- The `imem_addr_o` for the next fetch appears the cycle after RESOLVE.
- Branch/done inputs matter only in RESOLVE. They are ignored in all other states.
- `busy_o`, `halted_o`, `pc_o` are registered state decodes, not combinational from inputs.
- `instr_valid_o` is registered.

## Configuration
- `FETCH_CYCLE_COUNT_EN` defined: adds output `cycle_count_o` [15:0], plus one counter.
  - Clears on reset and on accepted `start_i`.
  - Increments every cycle `busy_o`=1.
  - Saturates at 16'hFFFF.
  - Holds in HALTED.
- Undefined: port and counter absent. Behaviour is otherwise identical.

## Structure
- Shared package `fetch_pkg`:
  - state enum.
  - OFFSET table constants, indices 0..7 = 1,2,3,4,6,8,12,16.
  - `FETCH_PC_W_DEFAULT` = 8.
- One sub-module, `branch_target`: combinational, (PC, sel, fwd, bwd) -> next PC, including the wrap rule.

## Test plan
- Reset mid-FETCH with `imem_req_o`=1 -> req drops in the same cycle. After release, IDLE, PC 0; a `imem_valid_i` pulse is ignored.
- `start_i`, memory returns 8'h41 with 2 wait cycles -> `instruction_o`=8'h41, `instr_valid_o` one cycle, PC 0->1 after RESOLVE, total 5 cycles.
- PC=10, `branchf_i`=1, `branch_sel_i`=5 in RESOLVE -> next `imem_addr_o`=18.
- PC=3, `branchb_i`=1, `branch_sel_i`=7 -> PC=243 (wrap, PC_W=8).
- PC=255, sequential -> PC=0.
- RESOLVE with `done_i`=1 and `branchf_i`=1 simultaneously -> HALTED, PC unchanged, no fetch. `start_i` then restarts at address 0. With `FETCH_CYCLE_COUNT_EN`, count is cleared and stays frozen while HALTED.
